// File: rtl/life_frame_buffer_if.sv
// CPU device-bus view of the Life frame buffer: one word per cycle write strobe,
// word address, write data and registered read data.
interface life_frame_buffer_if #(
    parameter int ADDR_WIDTH = 7,
    parameter int WORD_WIDTH = 32
);
    logic                  block_write;
    logic [ADDR_WIDTH-1:0] block_address;
    logic [WORD_WIDTH-1:0] block_data_in;
    logic [WORD_WIDTH-1:0] block_data_out;

    modport master (
        output block_write,
        output block_address,
        output block_data_in,
        input  block_data_out
    );

    modport slave (
        input  block_write,
        input  block_address,
        input  block_data_in,
        output block_data_out
    );
endinterface

// File: rtl/life_frame_buffer.sv
// Double-buffered Game of Life cell map: CPU writes the back buffer, reads and video
// scan the front buffer; swaps wait for vertical blank; a clear engine zeroes the back buffer.
module life_frame_buffer #(
    parameter int         COLS         = 64,
    parameter int         ROWS         = 48,
    parameter int         WORD_WIDTH   = 32,
    parameter int         CELL_SIZE    = 10,
    parameter int         ADDR_WIDTH   = 7,
    parameter logic [7:0] COLOR_LIVE   = 8'b000_000_00,
    parameter logic [7:0] COLOR_DEAD   = 8'b111_111_11,
    parameter logic [7:0] COLOR_BORDER = 8'b110_110_10
) (
    input  logic                clock,
    input  logic                reset,
    life_frame_buffer_if.slave  bus,
    input  logic [9:0]          x_position,
    input  logic [8:0]          y_position,
    input  logic                inside_video,
    input  logic                frame_start,
    output logic [7:0]          color
);
    localparam int WPR   = COLS / WORD_WIDTH;
    localparam int WORDS = ROWS * WPR;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int BIT_W = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;

    localparam logic [ADDR_WIDTH-1:0] CTRL_ADDR = '1;
    localparam logic [ADDR_WIDTH-1:0] WORDS_A   = ADDR_WIDTH'(WORDS);
    localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(WORDS - 1);
    localparam logic [9:0]            COLS_X    = 10'(COLS);
    localparam logic [8:0]            ROWS_Y    = 9'(ROWS);

    typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clear_cnt_q, clear_cnt_d;
    logic                  front_q, front_d;
    logic                  swap_pending_q, swap_pending_d;
    logic                  clear_busy, clear_we;

    logic                  ctrl_wr, clear_req, swap_req, swap_fire, data_we;
    logic                  back_bank, wr_en;
    logic [IDX_W-1:0]      wr_addr, cpu_idx;
    logic [WORD_WIDTH-1:0] wr_data;

    assign ctrl_wr   = bus.block_write && (bus.block_address == CTRL_ADDR);
    assign clear_req = ctrl_wr && bus.block_data_in[1];
    assign swap_req  = ctrl_wr && bus.block_data_in[0];
    assign data_we   = bus.block_write && (bus.block_address != CTRL_ADDR)
                       && (bus.block_address < WORDS_A) && !clear_busy;
    assign swap_fire = frame_start && swap_pending_q && !clear_busy;

    // Clear engine: state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            clear_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            clear_cnt_q <= clear_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        clear_cnt_d = clear_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (clear_req) begin
                    state_d     = ST_CLEAR;
                    clear_cnt_d = '0;
                end
            end
            ST_CLEAR: begin
                clear_cnt_d = clear_cnt_q + 1'b1;
                if (clear_cnt_q == LAST_WORD) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        clear_busy = (state_q == ST_CLEAR);
        clear_we   = clear_busy;
    end

    // A swap re-arm in the same cycle it fires is absorbed: pending only re-sets when idle.
    always_comb begin
        front_d        = front_q ^ swap_fire;
        swap_pending_d = swap_pending_q;
        if (swap_fire) begin
            swap_pending_d = 1'b0;
        end else if (swap_req) begin
            swap_pending_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            front_q        <= 1'b0;
            swap_pending_q <= 1'b0;
        end else begin
            front_q        <= front_d;
            swap_pending_q <= swap_pending_d;
        end
    end

    assign back_bank = ~front_q;
    assign wr_en     = data_we || clear_we;
    assign wr_addr   = clear_we ? IDX_W'(clear_cnt_q) : IDX_W'(bus.block_address);
    assign wr_data   = clear_we ? '0 : bus.block_data_in;
    assign cpu_idx   = IDX_W'(bus.block_address);

    logic [9:0]       x_cell_d, x_cell_q;
    logic [8:0]       y_cell_d, y_cell_q;
    logic             px_in_grid_d;
    logic [IDX_W-1:0] px_idx_d;
    logic             inside_q, px_front_q;

    always_comb begin
        x_cell_d     = 10'(x_position / CELL_SIZE);
        y_cell_d     = 9'(y_position / CELL_SIZE);
        px_in_grid_d = (x_cell_d < COLS_X) && (y_cell_d < ROWS_Y);
        px_idx_d     = '0;
        if (px_in_grid_d) begin
            px_idx_d = IDX_W'(int'(y_cell_d) * WPR + int'(x_cell_d) / WORD_WIDTH);
        end
    end

    // Each bank has one write port (back role) and two registered read ports (front role).
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : bank_g
            logic [WORD_WIDTH-1:0] mem_q [WORDS];
            logic [WORD_WIDTH-1:0] cpu_rd_q;
            logic [WORD_WIDTH-1:0] px_rd_q;

            always_ff @(posedge clock) begin
                if (wr_en && (back_bank == 1'(gi))) begin
                    mem_q[wr_addr] <= wr_data;
                end
                cpu_rd_q <= mem_q[cpu_idx];
                px_rd_q  <= mem_q[px_idx_d];
            end
        end
    endgenerate

    logic       rd_ctrl_q, rd_valid_q, rd_front_q;
    logic [2:0] status_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ctrl_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_front_q <= 1'b0;
            status_q   <= '0;
        end else begin
            rd_ctrl_q  <= (bus.block_address == CTRL_ADDR);
            rd_valid_q <= (bus.block_address < WORDS_A);
            rd_front_q <= front_q;
            status_q   <= {clear_busy, swap_pending_q, front_q};
        end
    end

    assign bus.block_data_out = rd_ctrl_q  ? {{(WORD_WIDTH-3){1'b0}}, status_q} :
                                rd_valid_q ? (rd_front_q ? bank_g[1].cpu_rd_q : bank_g[0].cpu_rd_q) :
                                             '0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            x_cell_q   <= '0;
            y_cell_q   <= '0;
            inside_q   <= 1'b0;
            px_front_q <= 1'b0;
        end else begin
            x_cell_q   <= x_cell_d;
            y_cell_q   <= y_cell_d;
            inside_q   <= inside_video;
            px_front_q <= front_q;
        end
    end

    logic [WORD_WIDTH-1:0] px_word;
    logic [BIT_W-1:0]      px_bit;
    logic [7:0]            color_d, color_q;

    always_comb begin
        px_word = px_front_q ? bank_g[1].px_rd_q : bank_g[0].px_rd_q;
        px_bit  = BIT_W'(x_cell_q % WORD_WIDTH);
        if (!inside_q) begin
            color_d = 8'h00;
        end else if ((x_cell_q >= COLS_X) || (y_cell_q >= ROWS_Y)) begin
            color_d = COLOR_BORDER;
        end else if (px_word[px_bit]) begin
            color_d = COLOR_LIVE;
        end else begin
            color_d = COLOR_DEAD;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            color_q <= 8'h00;
        end else begin
            color_q <= color_d;
        end
    end

    assign color = color_q;
endmodule

// File: tb/tb_life_frame_buffer.sv
// Directed bench for life_frame_buffer: default geometry (A) plus a 128x32 geometry (B).
module tb_life_frame_buffer;
    localparam logic [6:0] CTRL_A = 7'h7F;
    localparam logic [7:0] CTRL_B = 8'hFF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    life_frame_buffer_if #(.ADDR_WIDTH(7), .WORD_WIDTH(32)) bus_a ();
    life_frame_buffer_if #(.ADDR_WIDTH(8), .WORD_WIDTH(32)) bus_b ();

    logic [9:0] xa, xb;
    logic [8:0] ya, yb;
    logic       ina, inb, fsa, fsb;
    logic [7:0] color_a, color_b;

    life_frame_buffer dut_a (
        .clock(clk), .reset(rst), .bus(bus_a),
        .x_position(xa), .y_position(ya), .inside_video(ina),
        .frame_start(fsa), .color(color_a)
    );

    life_frame_buffer #(
        .COLS(128), .ROWS(32), .WORD_WIDTH(32), .CELL_SIZE(5), .ADDR_WIDTH(8)
    ) dut_b (
        .clock(clk), .reset(rst), .bus(bus_b),
        .x_position(xb), .y_position(yb), .inside_video(inb),
        .frame_start(fsb), .color(color_b)
    );

    int   tests_run = 0;
    int   failed    = 0;
    logic exp_front = 1'b0;

    // Helpers are entered at a falling edge and return at a falling edge.
    task automatic wr_a(input logic [6:0] a, input logic [31:0] d);
        bus_a.block_write = 1'b1; bus_a.block_address = a; bus_a.block_data_in = d;
        @(negedge clk);
        bus_a.block_write = 1'b0;
    endtask

    task automatic rd_a(input logic [6:0] a, output logic [31:0] d);
        bus_a.block_write = 1'b0; bus_a.block_address = a;
        @(negedge clk);
        d = bus_a.block_data_out;
    endtask

    task automatic frame_a();
        fsa = 1'b1;
        @(negedge clk);
        fsa = 1'b0;
    endtask

    task automatic swap_a();
        wr_a(CTRL_A, 32'h1);
        frame_a();
        exp_front = ~exp_front;
    endtask

    task automatic wait_clear_a(output int n);
        bus_a.block_address = CTRL_A;
        n = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bus_a.block_data_out[2]) n++;
            else if (n > 0) break;
        end
    endtask

    task automatic wr_b(input logic [7:0] a, input logic [31:0] d);
        bus_b.block_write = 1'b1; bus_b.block_address = a; bus_b.block_data_in = d;
        @(negedge clk);
        bus_b.block_write = 1'b0;
    endtask

    task automatic rd_b(input logic [7:0] a, output logic [31:0] d);
        bus_b.block_write = 1'b0; bus_b.block_address = a;
        @(negedge clk);
        d = bus_b.block_data_out;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        repeat (3) @(negedge clk);
        tests_run++;
        if (bus_a.block_data_out !== 32'h0) begin
            $display("FAIL rst_data_out_a got=%h exp=%h", bus_a.block_data_out, 32'h0); failed++;
        end
        tests_run++;
        if (color_a !== 8'h00) begin
            $display("FAIL rst_color_a got=%h exp=%h", color_a, 8'h00); failed++;
        end
        tests_run++;
        if (color_b !== 8'h00 || bus_b.block_data_out !== 32'h0) begin
            $display("FAIL rst_outputs_b color=%h data=%h exp=0", color_b, bus_b.block_data_out); failed++;
        end
        rst = 1'b0;
        exp_front = 1'b0;
        rd_a(CTRL_A, d);
        tests_run++;
        if (d !== 32'h0) begin
            $display("FAIL rst_status got=%h exp=%h", d, 32'h0); failed++;
        end
        $display("[TB] test_reset done");
    endtask

    task automatic init_a();
        int n;
        wr_a(CTRL_A, 32'h2); wait_clear_a(n); swap_a();
        wr_a(CTRL_A, 32'h2); wait_clear_a(n); swap_a();
    endtask

    task automatic test_swap();
        logic [31:0] d;
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        exp_front = 1'b0;
        wr_a(7'd0, 32'h0000_0002);
        wr_a(7'd1, 32'h8000_0000);
        wr_a(7'd2, 32'h0000_0001);
        rd_a(7'd0, d);
        tests_run++;
        if (d !== 32'h0) begin
            $display("FAIL swap_front_unchanged got=%h exp=%h", d, 32'h0); failed++;
        end
        wr_a(CTRL_A, 32'h1);
        rd_a(CTRL_A, d);
        tests_run++;
        if (d !== 32'h2) begin
            $display("FAIL swap_pending_status got=%h exp=%h", d, 32'h2); failed++;
        end
        frame_a();
        exp_front = 1'b1;
        rd_a(CTRL_A, d);
        tests_run++;
        if (d !== 32'h1) begin
            $display("FAIL swap_done_status got=%h exp=%h", d, 32'h1); failed++;
        end
        rd_a(7'd0, d);
        tests_run++;
        if (d !== 32'h0000_0002) begin
            $display("FAIL swap_new_front got=%h exp=%h", d, 32'h2); failed++;
        end
        $display("[TB] test_swap done front=%0d", exp_front);
    endtask

    task automatic test_pixel();
        logic [9:0] vx [11] = '{10'd0, 10'd10, 10'd10, 10'd639, 10'd620, 10'd0,
                                10'd10, 10'd640, 10'd0, 10'd19, 10'd0};
        logic [8:0] vy [11] = '{9'd0, 9'd0, 9'd0, 9'd0, 9'd0, 9'd10,
                                9'd10, 9'd0, 9'd480, 9'd9, 9'd479};
        logic       vi [11] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1,
                                1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [7:0] vc [11] = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00,
                                8'hFF, 8'hDA, 8'hDA, 8'h00, 8'hFF};
        for (int i = 0; i < 13; i++) begin
            if (i == 1) begin
                tests_run++;
                if (color_a !== 8'h00) begin
                    $display("FAIL pix_latency got=%h exp=%h", color_a, 8'h00); failed++;
                end
            end
            if (i >= 2) begin
                tests_run++;
                if (color_a !== vc[i-2]) begin
                    $display("FAIL pix_%0d x=%0d y=%0d in=%0d got=%h exp=%h",
                             i-2, vx[i-2], vy[i-2], vi[i-2], color_a, vc[i-2]);
                    failed++;
                end
            end
            if (i < 11) begin
                xa = vx[i]; ya = vy[i]; ina = vi[i];
            end else begin
                ina = 1'b0;
            end
            @(negedge clk);
        end
        $display("[TB] test_pixel done");
    endtask

    task automatic test_clear();
        logic [31:0] d;
        int n;
        wr_a(7'd0, 32'hFFFF_FFFF);
        wr_a(7'd50, 32'hFFFF_FFFF);
        wr_a(7'd95, 32'hFFFF_FFFF);
        wr_a(CTRL_A, 32'h2);
        wait_clear_a(n);
        tests_run++;
        if (n != 96) begin
            $display("FAIL clear_busy_cycles got=%0d exp=%0d", n, 96); failed++;
        end
        wr_a(CTRL_A, 32'h2);
        repeat (49) @(negedge clk);
        wr_a(7'd5, 32'hDEAD_BEEF);
        wait_clear_a(n);
        tests_run++;
        if (n < 1 || n > 47) begin
            $display("FAIL clear_remaining_after_write got=%0d exp=1..47", n); failed++;
        end
        swap_a();
        for (int i = 0; i < 96; i++) begin
            rd_a(7'(i), d);
            tests_run++;
            if (d !== 32'h0) begin
                $display("FAIL clear_word_%0d got=%h exp=%h", i, d, 32'h0); failed++;
            end
        end
        $display("[TB] test_clear done front=%0d", exp_front);
    endtask

    task automatic test_swap_during_clear();
        logic [31:0] d;
        wr_a(CTRL_A, 32'h3);
        frame_a();
        rd_a(CTRL_A, d);
        tests_run++;
        if (d !== {29'd0, 1'b1, 1'b1, exp_front}) begin
            $display("FAIL busy_swap_blocked got=%h exp=%h", d, {29'd0, 1'b1, 1'b1, exp_front}); failed++;
        end
        repeat (93) @(negedge clk);
        frame_a();
        rd_a(CTRL_A, d);
        tests_run++;
        if (d !== {29'd0, 1'b0, 1'b1, exp_front}) begin
            $display("FAIL last_cycle_no_swap got=%h exp=%h", d, {29'd0, 1'b0, 1'b1, exp_front}); failed++;
        end
        frame_a();
        exp_front = ~exp_front;
        rd_a(CTRL_A, d);
        tests_run++;
        if (d !== {29'd0, 1'b0, 1'b0, exp_front}) begin
            $display("FAIL swap_after_clear got=%h exp=%h", d, {29'd0, 1'b0, 1'b0, exp_front}); failed++;
        end
        rd_a(7'd0, d);
        tests_run++;
        if (d !== 32'h0) begin
            $display("FAIL cleared_front_word0 got=%h exp=%h", d, 32'h0); failed++;
        end
        $display("[TB] test_swap_during_clear done front=%0d", exp_front);
    endtask

    task automatic test_reset_mid_clear();
        logic [31:0] d;
        logic [31:0] exp;
        logic        filled;
        filled = ~exp_front;
        for (int i = 0; i < 96; i++) wr_a(7'(i), 32'hA500_0000 | 32'(i));
        wr_a(CTRL_A, 32'h2);
        repeat (40) @(negedge clk);
        rst = 1'b1;
        #1;
        tests_run++;
        if (bus_a.block_data_out !== 32'h0) begin
            $display("FAIL rst_async_data_out got=%h exp=%h", bus_a.block_data_out, 32'h0); failed++;
        end
        @(negedge clk);
        rst = 1'b0;
        exp_front = 1'b0;
        rd_a(CTRL_A, d);
        tests_run++;
        if (d !== 32'h0) begin
            $display("FAIL rst_mid_clear_status got=%h exp=%h", d, 32'h0); failed++;
        end
        if (filled != exp_front) swap_a();
        for (int i = 0; i < 96; i++) begin
            rd_a(7'(i), d);
            exp = (i < 40) ? 32'h0 : (32'hA500_0000 | 32'(i));
            tests_run++;
            if (d !== exp) begin
                $display("FAIL partial_clear_word_%0d got=%h exp=%h", i, d, exp); failed++;
            end
        end
        $display("[TB] test_reset_mid_clear done");
    endtask

    task automatic test_param_b();
        logic [31:0] d;
        int n;
        logic [9:0] vx [6] = '{10'd500, 10'd495, 10'd640, 10'd0,  10'd504, 10'd505};
        logic [8:0] vy [6] = '{9'd155,  9'd155,  9'd0,   9'd160, 9'd159,  9'd155};
        logic [7:0] vc [6] = '{8'h00,   8'hFF,   8'hDA,  8'hDA,  8'h00,   8'hFF};
        wr_b(CTRL_B, 32'h2);
        bus_b.block_address = CTRL_B;
        n = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bus_b.block_data_out[2]) n++;
            else if (n > 0) break;
        end
        tests_run++;
        if (n != 128) begin
            $display("FAIL b_clear_cycles got=%0d exp=%0d", n, 128); failed++;
        end
        wr_b(8'd127, 32'h0000_0010);
        wr_b(CTRL_B, 32'h1);
        fsb = 1'b1; @(negedge clk); fsb = 1'b0;
        rd_b(CTRL_B, d);
        tests_run++;
        if (d !== 32'h1) begin
            $display("FAIL b_status got=%h exp=%h", d, 32'h1); failed++;
        end
        rd_b(8'd127, d);
        tests_run++;
        if (d !== 32'h10) begin
            $display("FAIL b_word127 got=%h exp=%h", d, 32'h10); failed++;
        end
        for (int i = 0; i < 8; i++) begin
            if (i >= 2) begin
                tests_run++;
                if (color_b !== vc[i-2]) begin
                    $display("FAIL b_pix_%0d x=%0d y=%0d got=%h exp=%h",
                             i-2, vx[i-2], vy[i-2], color_b, vc[i-2]);
                    failed++;
                end
            end
            if (i < 6) begin
                xb = vx[i]; yb = vy[i]; inb = 1'b1;
            end else begin
                inb = 1'b0;
            end
            @(negedge clk);
        end
        $display("[TB] test_param_b done");
    endtask

    initial begin
        bus_a.block_write = 1'b0; bus_a.block_address = '0; bus_a.block_data_in = '0;
        bus_b.block_write = 1'b0; bus_b.block_address = '0; bus_b.block_data_in = '0;
        xa = '0; ya = '0; ina = 1'b0; fsa = 1'b0;
        xb = '0; yb = '0; inb = 1'b0; fsb = 1'b0;
        test_reset();
        init_a();
        test_swap();
        test_pixel();
        test_clear();
        test_swap_during_clear();
        test_reset_mid_clear();
        test_param_b();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

    initial begin
        #10000000;
        $display("FAIL watchdog timeout tests_run=%0d", tests_run);
        $fatal(1, "watchdog");
    end
endmodule
